// File: rtl/pulse_capture_monitor.sv
// Measures high pulses on a possibly-asynchronous line and queues one {gap, width}
// record per pulse in a small FIFO read through a valid/ready port.
module pulse_capture_monitor #(
  parameter int CNT_W       = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             clr,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_width,
  output logic [CNT_W-1:0] rec_gap,
  output logic             rec_first,
  output logic             rec_sat,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = 2 * CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic [SYNC_STAGES:0] sync_r;
  logic                 din_s;
  logic                 din_q_s;
  logic                 rise_s;
  logic                 fall_s;
  state_t               state_r;
  logic [CNT_W-1:0]     wcnt_r;
  logic [CNT_W-1:0]     gcnt_r;
  logic [CNT_W-1:0]     wcnt_inc_s;
  logic [CNT_W-1:0]     gcnt_inc_s;
  logic                 first_r;
  logic                 sat_r;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 store_s;
  logic                 drop_s;
  logic [RW-1:0]        push_rec_s;
  logic [RW-1:0]        head_s;
  logic [RW-1:0]        mem_r [DEPTH];
  logic [PW-1:0]        wptr_r;
  logic [PW-1:0]        rptr_r;
  logic                 overflow_r;
  logic [7:0]           drop_cnt_r;

  // Synchronizer chain; the extra top bit is the one-cycle-delayed copy used for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {(SYNC_STAGES + 1){1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-1:0], din};
    end
  end

  // Edge detect, saturating increments, record assembly and FIFO handshake decode.
  always_comb begin
    din_s      = sync_r[SYNC_STAGES-1];
    din_q_s    = sync_r[SYNC_STAGES];
    rise_s     = din_s & ~din_q_s;
    fall_s     = ~din_s & din_q_s;
    wcnt_inc_s = (wcnt_r == CNT_MAX) ? CNT_MAX : (wcnt_r + CNT_W'(1));
    gcnt_inc_s = (gcnt_r == CNT_MAX) ? CNT_MAX : (gcnt_r + CNT_W'(1));
    push_s     = (state_r == HIGH) && fall_s && !clr;
    push_rec_s = {first_r, sat_r, (first_r ? {CNT_W{1'b0}} : gcnt_r), wcnt_r};
    empty_s    = (wptr_r == rptr_r);
    full_s     = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    pop_s      = !empty_s && rec_ready;
    store_s    = push_s && (!full_s || pop_s);
    drop_s     = push_s && full_s && !pop_s;
    head_s     = empty_s ? {RW{1'b0}} : mem_r[rptr_r[AW-1:0]];
  end

  assign rec_valid = !empty_s;
  assign {rec_first, rec_sat, rec_gap, rec_width} = head_s;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;

  // Pulse measurement FSM; sat_r spans a pulse and the gap that preceded it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      wcnt_r  <= {CNT_W{1'b0}};
      gcnt_r  <= {CNT_W{1'b0}};
      first_r <= 1'b0;
      sat_r   <= 1'b0;
    end else if (clr) begin
      state_r <= IDLE;
      wcnt_r  <= {CNT_W{1'b0}};
      gcnt_r  <= {CNT_W{1'b0}};
      first_r <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r <= HIGH;
            wcnt_r  <= CNT_W'(1);
            first_r <= 1'b1;
            sat_r   <= 1'b0;
          end
        end
        HIGH: begin
          if (fall_s) begin
            state_r <= LOW;
            gcnt_r  <= CNT_W'(1);
            sat_r   <= 1'b0;
          end else begin
            wcnt_r <= wcnt_inc_s;
            sat_r  <= sat_r | (wcnt_inc_s == CNT_MAX);
          end
        end
        LOW: begin
          if (rise_s) begin
            state_r <= HIGH;
            wcnt_r  <= CNT_W'(1);
            first_r <= 1'b0;
          end else begin
            gcnt_r <= gcnt_inc_s;
            sat_r  <= sat_r | (gcnt_inc_s == CNT_MAX);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers; one extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
    end else if (clr) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
    end else begin
      if (store_s) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
    end
  end

  // Record storage; the head is masked to zero while empty so stale entries never show.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wptr_r[AW-1:0]] <= push_rec_s;
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (clr) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 8'd255) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

endmodule
